// File: rtl/end_pulse_gen_if.sv
// Handshake bundle between main control / timing and the end-pulse generator.
// Main control holds the master side; end_pulse_gen takes the slave side.
interface end_pulse_gen_if #(
  parameter int CNT_W = 6
) ();
  logic             g13;
  logic [2:0]       order_class;
  logic [CNT_W-1:0] shift_n;
  logic             mul_done;
  logic             d0;
  logic             d18;
  logic             eng_single;
  logic             single_key;
  logic             ep;
  logic             single_ep;
  logic             stop_one;
  logic             busy;

  modport master (
    output g13, order_class, shift_n, mul_done, d0, d18, eng_single, single_key,
    input  ep, single_ep, stop_one, busy
  );

  modport slave (
    input  g13, order_class, shift_n, mul_done, d0, d18, eng_single, single_key,
    output ep, single_ep, stop_one, busy
  );
endinterface

// File: rtl/end_pulse_gen.sv
// End Pulse generator: times a Stage 2 order in minor cycles and closes the
// handshake with ep, or with single_ep from the operator key in single-shot mode.
module end_pulse_gen #(
  parameter int ARITH_CYCLES = 2,
  parameter int CNT_W        = 6,
  parameter int SYNC_STAGES  = 2
) (
  input logic           clk,
  input logic           rst_n,
  end_pulse_gen_if.slave epg
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] COUNT    = 3'd1;
  localparam logic [2:0] WAIT_MUL = 3'd2;
  localparam logic [2:0] ISSUE    = 3'd3;
  localparam logic [2:0] HALT     = 3'd4;
  localparam logic [2:0] HOLD     = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int ARITH_SAT = (ARITH_CYCLES > CNT_MAX) ? CNT_MAX :
                             ((ARITH_CYCLES < 1) ? 1 : ARITH_CYCLES);
  localparam logic [CNT_W-1:0] ARITH_LOAD = ARITH_SAT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ep_q, ep_d;
  logic                   single_ep_q, single_ep_d;
  logic                   stop_one_q, stop_one_d;
  logic                   g13_q;
  logic [SYNC_STAGES-1:0] key_sync_q;
  logic                   key_prev_q;

  logic                   start;
  logic                   key_edge;
  logic [CNT_W-1:0]       load_val;

  assign start    = epg.g13 & ~g13_q;
  assign key_edge = key_sync_q[SYNC_STAGES-1] & ~key_prev_q;

  // Class 3 and 4 do not use the counter, so they simply load zero.
  always_comb begin
    load_val = CNT_ONE;
    case (epg.order_class)
      3'd1:    load_val = ARITH_LOAD;
      3'd2:    load_val = (epg.shift_n == CNT_ZERO) ? CNT_ONE : epg.shift_n;
      3'd3,
      3'd4:    load_val = CNT_ZERO;
      default: load_val = CNT_ONE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ep_d        = 1'b0;
    single_ep_d = 1'b0;
    stop_one_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = load_val;
          case (epg.order_class)
            3'd3:    state_d = WAIT_MUL;
            3'd4: begin
              state_d    = HALT;
              stop_one_d = 1'b1;
            end
            default: state_d = COUNT;
          endcase
        end else if (key_edge && epg.eng_single) begin
          single_ep_d = 1'b1;
        end
      end
      COUNT: begin
        if (!epg.g13) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = ISSUE;
        end else if (epg.d0) begin
          // Leaving for ISSUE here means a d18 in this same clk is never seen as qualifying.
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ISSUE;
        end
      end
      WAIT_MUL: begin
        if (!epg.g13)         state_d = IDLE;
        else if (epg.mul_done) state_d = ISSUE;
      end
      ISSUE: begin
        if (!epg.g13) begin
          state_d = IDLE;
        end else if (epg.d18) begin
          if (epg.eng_single) begin
            state_d = HOLD;
          end else begin
            ep_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      HALT, HOLD: begin
        if (!epg.g13) begin
          state_d = IDLE;
        end else if (key_edge) begin
          single_ep_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (!epg.g13) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ep_q        <= 1'b0;
      single_ep_q <= 1'b0;
      stop_one_q  <= 1'b0;
      g13_q       <= 1'b0;
      key_sync_q  <= '0;
      key_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ep_q        <= ep_d;
      single_ep_q <= single_ep_d;
      stop_one_q  <= stop_one_d;
      g13_q       <= epg.g13;
      key_sync_q  <= {key_sync_q[SYNC_STAGES-2:0], epg.single_key};
      key_prev_q  <= key_sync_q[SYNC_STAGES-1];
    end
  end

  assign epg.ep        = ep_q;
  assign epg.single_ep = single_ep_q;
  assign epg.stop_one  = stop_one_q;
  assign epg.busy      = (state_q != IDLE);

endmodule
